// File: rtl/ppu_sprite_pkg.sv
// Shared encodings for the PPU sprite pattern fetch path: sequencer states,
// secondary-OAM field offsets, OAM attribute bit positions and buffer-attr packing.
package ppu_sprite_pkg;

  typedef enum logic [3:0] {
    ST_IDLE,
    ST_RD_Y,
    ST_RD_TILE,
    ST_RD_ATTR,
    ST_RD_X,
    ST_LO_ADDR,
    ST_LO_DATA,
    ST_HI_ADDR,
    ST_HI_DATA
  } fetch_state_t;

  localparam logic [1:0] OAM_Y    = 2'd0;
  localparam logic [1:0] OAM_TILE = 2'd1;
  localparam logic [1:0] OAM_ATTR = 2'd2;
  localparam logic [1:0] OAM_X    = 2'd3;

  localparam int unsigned ATTR_VFLIP = 7;
  localparam int unsigned ATTR_HFLIP = 6;
  localparam int unsigned ATTR_PRIO  = 5;

  localparam int unsigned DOTS_PER_SLOT = 8;

  // Sprite buffer attribute order: {hflip, priority, palette[1:0]}
  function automatic logic [3:0] pack_attr(input logic [7:0] attr);
    return {attr[ATTR_HFLIP], attr[ATTR_PRIO], attr[1:0]};
  endfunction

endpackage

// File: rtl/sprite_pattern_addr.sv
// Pattern-table address generation for one sprite row: row offset, vertical
// flip and 8x8 / 8x16 table layout.
module sprite_pattern_addr (
  input  logic [7:0]  scanline,
  input  logic [7:0]  y,
  input  logic [7:0]  tile,
  input  logic        vflip,
  input  logic        sprite_16,
  input  logic        sprite_table,
  input  logic        plane,
  output logic [13:0] addr
);

  logic [7:0] dy;
  logic [3:0] row;

  always_comb begin
    dy  = scanline - y;
    row = dy[3:0];
    if (vflip) row = sprite_16 ? ~row : {row[3], ~row[2:0]};
    // 8x16 takes the table from tile[0]; row[3] picks the bottom tile
    if (sprite_16) addr = {1'b0, tile[0], tile[7:1], row[3], plane, row[2:0]};
    else           addr = {1'b0, sprite_table, tile, plane, row[2:0]};
  end

endmodule

// File: rtl/sprite_fetch_ctrl.sv
// Per-line sprite pattern fetch sequencer (dots 257-320): walks secondary OAM,
// issues VRAM reads, loads the sprite buffers. Optional: SPRITE0_TRACK_EN.
module sprite_fetch_ctrl
  import ppu_sprite_pkg::*;
#(
  parameter int unsigned NUM_SLOTS = 8,
  parameter int unsigned VRAM_AW   = 14
) (
  input  logic                 clk,
  input  logic                 rst,
`ifdef SPRITE0_TRACK_EN
  input  logic                 sprite0_on_line,
  output logic                 sprite0_slot_valid,
`endif
  input  logic                 next_pixel,
  input  logic                 fetch_start,
  input  logic [7:0]           scanline,
  input  logic [3:0]           sprite_count,
  input  logic                 sprite_16,
  input  logic                 sprite_table,
  output logic [4:0]           soam_addr,
  input  logic [7:0]           soam_data,
  output logic [VRAM_AW-1:0]   vram_addr,
  output logic                 vram_rd,
  input  logic [7:0]           vram_data,
  output logic [NUM_SLOTS-1:0] pattern0_ld,
  output logic [NUM_SLOTS-1:0] pattern1_ld,
  output logic                 valid_out,
  output logic [3:0]           sprite_attr_out,
  output logic [7:0]           sprite_x_out,
  output logic [7:0]           pattern_out,
  output logic                 busy,
  output logic                 fetch_done
);

  fetch_state_t state, state_nx;

  logic [2:0]  slot, ld_slot;
  logic        slot_valid, vflip_q;
  logic [7:0]  y_q, tile_q, x_q;
  logic [3:0]  attr_q;
  logic        ld0_pend, ld1_pend, last_pend;
  logic        start, last_slot, cur_valid, plane;
  logic [13:0] pat_addr;
  logic [NUM_SLOTS-1:0] ld_mask;

  assign start     = (state == ST_IDLE) && fetch_start && !busy;
  assign last_slot = (slot == 3'(NUM_SLOTS - 1));
  assign cur_valid = ({1'b0, slot} < sprite_count);
  assign plane     = (state == ST_LO_DATA);
  assign ld_mask   = NUM_SLOTS'(1) << ld_slot;

  sprite_pattern_addr u_addr (
    .scanline     (scanline),
    .y            (y_q),
    .tile         (tile_q),
    .vflip        (vflip_q),
    .sprite_16    (sprite_16),
    .sprite_table (sprite_table),
    .plane        (plane),
    .addr         (pat_addr)
  );

  always_ff @(posedge clk) begin
    if (!rst) state <= ST_IDLE;
    else      state <= state_nx;
  end

  always_comb begin
    state_nx  = state;
    soam_addr = '0;
    case (state)
      ST_IDLE:    if (start) state_nx = ST_RD_Y;
      ST_RD_Y:    begin soam_addr = {slot, OAM_Y};    if (next_pixel) state_nx = ST_RD_TILE; end
      ST_RD_TILE: begin soam_addr = {slot, OAM_TILE}; if (next_pixel) state_nx = ST_RD_ATTR; end
      ST_RD_ATTR: begin soam_addr = {slot, OAM_ATTR}; if (next_pixel) state_nx = ST_RD_X;    end
      ST_RD_X:    begin soam_addr = {slot, OAM_X};    if (next_pixel) state_nx = ST_LO_ADDR; end
      ST_LO_ADDR: if (next_pixel) state_nx = ST_LO_DATA;
      ST_LO_DATA: if (next_pixel) state_nx = ST_HI_ADDR;
      ST_HI_ADDR: if (next_pixel) state_nx = ST_HI_DATA;
      ST_HI_DATA: if (next_pixel) state_nx = last_slot ? ST_IDLE : ST_RD_Y;
      default:    state_nx = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      slot <= '0;  ld_slot <= '0;  slot_valid <= 1'b0;
      y_q <= '0;  tile_q <= '0;  x_q <= '0;  attr_q <= '0;  vflip_q <= 1'b0;
      ld0_pend <= 1'b0;  ld1_pend <= 1'b0;  last_pend <= 1'b0;
      vram_addr <= '0;  vram_rd <= 1'b0;
      pattern0_ld <= '0;  pattern1_ld <= '0;
      valid_out <= 1'b0;  sprite_attr_out <= '0;  sprite_x_out <= '0;  pattern_out <= '0;
      busy <= 1'b0;  fetch_done <= 1'b0;
    end else begin
      vram_rd     <= 1'b0;
      pattern0_ld <= ld0_pend ? ld_mask : '0;
      pattern1_ld <= ld1_pend ? ld_mask : '0;
      fetch_done  <= last_pend;
      ld0_pend    <= 1'b0;
      ld1_pend    <= 1'b0;
      last_pend   <= 1'b0;
      if (last_pend) busy <= 1'b0;
      if (start) begin
        busy <= 1'b1;
        slot <= '0;
      end
      if (next_pixel) begin
        case (state)
          ST_RD_Y: begin
            slot_valid <= cur_valid;
            y_q        <= cur_valid ? soam_data : 8'hFF;
          end
          ST_RD_TILE: tile_q <= slot_valid ? soam_data : 8'hFF;
          ST_RD_ATTR: begin
            vflip_q <= soam_data[ATTR_VFLIP];
            attr_q  <= pack_attr(soam_data);
          end
          ST_RD_X: begin
            x_q       <= soam_data;
            vram_addr <= VRAM_AW'(pat_addr);
            vram_rd   <= 1'b1;
          end
          ST_LO_DATA, ST_HI_DATA: begin
            // Buses settle here; the strobe follows one clk later with them stable
            valid_out       <= slot_valid;
            sprite_attr_out <= attr_q;
            sprite_x_out    <= x_q;
            pattern_out     <= slot_valid ? vram_data : 8'h00;
            ld_slot         <= slot;
            if (state == ST_LO_DATA) begin
              ld0_pend  <= 1'b1;
              vram_addr <= VRAM_AW'(pat_addr);
              vram_rd   <= 1'b1;
            end else begin
              ld1_pend  <= 1'b1;
              last_pend <= last_slot;
              slot      <= last_slot ? 3'd0 : slot + 3'd1;
            end
          end
          default: ;
        endcase
      end
    end
  end

`ifdef SPRITE0_TRACK_EN
  logic s0_flag;

  always_ff @(posedge clk) begin
    if (!rst) begin
      s0_flag            <= 1'b0;
      sprite0_slot_valid <= 1'b0;
    end else begin
      if (start)     s0_flag <= sprite0_on_line;
      if (last_pend) sprite0_slot_valid <= s0_flag && (sprite_count != 4'd0);
    end
  end
`endif

endmodule

// File: doc/sprite_fetch_ctrl.md
Name: sprite_fetch_ctrl

Overview:
Sequences the per-line sprite pattern fetch during PPU dots 257–320. It walks secondary OAM (8 slots × 4 bytes) and computes pattern-table addresses for each slot. It then issues VRAM reads and drives the shared load bus that fills the eight sprite_buffer instances, using one-hot pattern0_ld/pattern1_ld strobes. It sits between secondary-OAM evaluation and the sprite buffer bank in the PPU.

Parameters:
NUM_SLOTS, 8, number of sprite buffers/secondary-OAM slots (1..8).
VRAM_AW, 14, PPU VRAM address width.

Ports:
clk  in  1  PPU clock.
rst  in  1  reset, synchronous, active-low (rst=0 resets).
next_pixel  in  1  dot strobe; never high on two consecutive clks.
fetch_start  in  1  one-clk pulse at dot 257.
scanline  in  8  line being prepared (next rendered line).
sprite_count  in  4  valid secondary-OAM entries, 0..8.
sprite_16  in  1  PPUCTRL[5], 8x16 sprites.
sprite_table  in  1  PPUCTRL[3], 8x8 pattern table select.
soam_addr  out  5  secondary-OAM byte address {slot, field}.
soam_data  in  8  secondary-OAM read data, 1-clk sync read.
vram_addr  out  VRAM_AW  pattern fetch address.
vram_rd  out  1  one-clk read request.
vram_data  in  8  read data; valid by the dot strobe ending the DATA state.
pattern0_ld  out  NUM_SLOTS  one-hot low-plane load strobe.
pattern1_ld  out  NUM_SLOTS  one-hot high-plane load strobe.
valid_out  out  1  slot holds a real sprite.
sprite_attr_out  out  4  {hflip, priority, palette[1:0]}.
sprite_x_out  out  8  sprite X.
pattern_out  out  8  pattern byte for the pending strobe.
busy  out  1  fetch sequence active.
fetch_done  out  1  one-clk pulse after the last slot's pattern1_ld.

Behaviour:
- Reset (rst=0 at clk edge): state IDLE, slot=0, all strobes, vram_rd, busy, fetch_done=0; buses 0.
- States: IDLE, RD_Y, RD_TILE, RD_ATTR, RD_X, LO_ADDR, LO_DATA, HI_ADDR, HI_DATA. Every non-IDLE state lasts exactly one next_pixel, giving 8 dots per slot and 64 dots for 8 slots.
- IDLE→RD_Y with slot=0 on fetch_start. fetch_start while busy is ignored.
- RD_*: soam_addr={slot,field}, with field Y=0, TILE=1, ATTR=2, X=3. soam_data is captured on the next_pixel that leaves the state.
- Slot invalid (slot>=sprite_count): Y and tile are forced to 0xFF, valid_out=0, and pattern_out is forced to 0x00. The VRAM reads are still issued, preserving A12 toggles for mappers.
- Row: row=scanline−Y (8-bit wrap). If attr[7] (vflip), row[3:0] is inverted (8x16) or row[2:0] is inverted (8x8).
- Address for 8x8: {0, sprite_table, tile[7:0], plane, row[2:0]}.
- Address for 8x16: {0, tile[0], tile[7:1], row[3], plane, row[2:0]}.
- plane=0 in LO_*, 1 in HI_*. vram_addr is held through ADDR and DATA; vram_rd is high for the first clk of LO_ADDR and of HI_ADDR.
- Outputs are registered. On the next_pixel ending LO_DATA, the block captures vram_data and drives valid/attr/x/pattern. On the following clk, pattern0_ld[slot]=1 for exactly one clk, with the buses stable that clk.
- HI_DATA ends the same way with pattern1_ld[slot]. The buses hold until the next capture.
- sprite_attr_out={attr[6], attr[5], attr[1:0]}.
- After slot NUM_SLOTS−1 HI_DATA: fetch_done is pulsed with pattern1_ld, busy falls, and the state returns to IDLE. Otherwise slot increments and the state goes to RD_Y.
- Reset mid-sequence: abort immediately to IDLE; no further strobes.
- next_pixel low: the state holds.

Optional Feature:
Macro SPRITE0_TRACK_EN.
- With it: input sprite0_on_line (1) is sampled at fetch_start. Output sprite0_slot_valid (1) updates on the fetch_done clk to sampled_flag && sprite_count!=0, and holds until the next fetch_done; its reset value is 0. This feeds sprite-0-hit logic.
- Without it: the port and its logic are absent.

Decomposition:
- Package ppu_sprite_pkg holds: state encodings, OAM field offsets (Y/TILE/ATTR/X), OAM attr bit positions (VFLIP=7, HFLIP=6, PRIO=5), buffer-attr packing order, and dots-per-slot=8.
- One sub-module, sprite_pattern_addr: combinational row/vflip/8x16 address generation from scanline, Y, tile, attr, sprite_16, sprite_table, plane.

Test Plan:
1. sprite_count=1, slot0 {Y=0x10, tile=0x42, attr=0x00, X=0x30}, scanline=0x13, sprite_table=0, 8x8 → LO vram_addr=0x0423, HI=0x042B. pattern0_ld=0x01 with attr_out=0, x_out=0x30, valid=1. Strobes for slots 1–7 have valid=0, pattern 0, address 0x0FF?; fetch_done 64 dots after start.
2. 8x16, tile=0x43, attr=0x80 (vflip), Y=0x20, scanline=0x22 → row=2 inverted to 13 → LO vram_addr=0x1435, HI=0x143D.
3. attr=0x61 → sprite_attr_out=4'b1101. The pattern bytes 0xA5/0x3C appear on pattern_out during pattern0_ld/pattern1_ld respectively.
4. Second fetch_start pulse at dot 20 of a sequence → ignored; strobe count stays 8+8; fetch_done once.
5. rst=0 during slot 3 LO_ADDR → next clk all outputs 0, IDLE; no strobes until a new fetch_start.
6. next_pixel every 3 clks vs every 2 clks → identical strobe order and values; each ld exactly one clk wide.
